// File: rtl/fp_pkg.sv
// Shared constants and the alignment-stage state type for the binary32 adder.
package fp_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int ALIGN_W   = 27;
  localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int EXP_BIAS  = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } align_state_e;
endpackage

// File: rtl/fp_sticky_shift.sv
// Combinational right shift by 0..STEP; every bit pushed out is ORed into bit 0.
module fp_sticky_shift
  import fp_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic [ALIGN_W-1:0] din,
  input  logic [4:0]         k,
  output logic [ALIGN_W-1:0] dout
);
  logic [ALIGN_W-1:0] mask;
  logic [ALIGN_W-1:0] shifted;
  logic               lost;

  assign mask    = ~({ALIGN_W{1'b1}} << k);
  assign shifted = din >> k;
  // Old bit 0 is inside the mask whenever k>0, so it feeds the sticky as well.
  assign lost    = |(din & mask);
  assign dout    = {shifted[ALIGN_W-1:1], shifted[0] | lost};
endmodule

// File: rtl/fp_add_align.sv
// Pre-alignment stage: orders two binary32 operands by magnitude and shifts
// the smaller mantissa right by the exponent difference, STEP bits per cycle.
module fp_add_align
  import fp_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int MAX_SHIFT = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALIGN_W-1:0] out_man_big,
  output logic [ALIGN_W-1:0] out_man_small,
  output logic [7:0]         out_exp,
  output logic               out_sign_big,
  output logic               out_sign_small,
  output logic               out_eff_sub,
  output logic               out_special
);
  align_state_e state_reg, state_next;

  logic [31:0]        a_reg, b_reg;
  logic [ALIGN_W-1:0] man_big_reg, man_small_reg;
  logic [7:0]         exp_reg;
  logic               sign_big_reg, sign_small_reg, special_reg;
  logic [4:0]         rem_reg;

  logic [7:0]         exp_a, exp_b, exp_big, exp_small, diff;
  logic [ALIGN_W-1:0] man_a, man_b, shift_out;
  logic               a_big, special;
  logic [4:0]         d, k;

  // Zero exponent means subnormal/zero: no hidden bit, effective exponent 1.
  assign exp_a = (a_reg[30:23] == 8'd0) ? 8'd1 : a_reg[30:23];
  assign exp_b = (b_reg[30:23] == 8'd0) ? 8'd1 : b_reg[30:23];
  assign man_a = {|a_reg[30:23], a_reg[22:0], 3'b000};
  assign man_b = {|b_reg[30:23], b_reg[22:0], 3'b000};

  assign a_big     = (exp_a > exp_b) || ((exp_a == exp_b) && (man_a >= man_b));
  assign special   = (a_reg[30:23] == EXP_MAX) || (b_reg[30:23] == EXP_MAX);
  assign exp_big   = a_big ? exp_a : exp_b;
  assign exp_small = a_big ? exp_b : exp_a;
  assign diff      = exp_big - exp_small;
  assign d         = (diff > 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : diff[4:0];
  assign k         = (rem_reg > 5'(STEP)) ? 5'(STEP) : rem_reg;

  fp_sticky_shift #(.STEP(STEP)) u_shift (
    .din  (man_small_reg),
    .k    (k),
    .dout (shift_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (in_valid) state_next = ST_CMP;
      ST_CMP:   state_next = (special || d == 5'd0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (rem_reg <= 5'(STEP)) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg          <= '0;
      b_reg          <= '0;
      man_big_reg    <= '0;
      man_small_reg  <= '0;
      exp_reg        <= '0;
      sign_big_reg   <= 1'b0;
      sign_small_reg <= 1'b0;
      special_reg    <= 1'b0;
      rem_reg        <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
        end
        ST_CMP: begin
          man_big_reg    <= a_big ? man_a : man_b;
          man_small_reg  <= a_big ? man_b : man_a;
          exp_reg        <= exp_big;
          sign_big_reg   <= a_big ? a_reg[31] : b_reg[31];
          sign_small_reg <= a_big ? b_reg[31] : a_reg[31];
          special_reg    <= special;
          rem_reg        <= special ? 5'd0 : d;
        end
        ST_SHIFT: begin
          man_small_reg <= shift_out;
          rem_reg       <= rem_reg - k;
        end
        default: ;
      endcase
    end
  end

  assign in_ready       = (state_reg == ST_IDLE);
  assign out_valid      = (state_reg == ST_DONE);
  assign out_man_big    = man_big_reg;
  assign out_man_small  = man_small_reg;
  assign out_exp        = exp_reg;
  assign out_sign_big   = sign_big_reg;
  assign out_sign_small = sign_small_reg;
  assign out_eff_sub    = sign_big_reg ^ sign_small_reg;
  assign out_special    = special_reg;
endmodule
